// File: rtl/gcd_stein.sv
// Multi-cycle binary (Stein) GCD engine: shifts and subtracts only, start/ready
// handshake, registered result-valid flag and zero-operand shortcut.
module gcd_stein #(
  parameter  int unsigned WIDTH = 16,
  localparam int unsigned KW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             fin,
  output logic [WIDTH-1:0] o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STRIP,
    S_REDUCE,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] o_q, o_d;
  logic [KW-1:0]    k_q, k_d;
  logic             fin_q, fin_d;
  logic             ready_q, ready_d;

  // State and datapath registers
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= S_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      o_q     <= '0;
      k_q     <= '0;
      fin_q   <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      o_q     <= o_d;
      k_q     <= k_d;
      fin_q   <= fin_d;
      ready_q <= ready_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    o_d     = o_q;
    k_d     = k_q;
    fin_d   = 1'b0;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          x_d = a;
          y_d = b;
          k_d = '0;
          if ((a == '0) || (b == '0)) begin
            o_d     = a | b;
            state_d = S_DONE;
          end else begin
            state_d = S_STRIP;
          end
        end else begin
          // fin trails entry into DONE by one cycle and drops on the accepting edge
          fin_d = (state_q == S_DONE);
        end
      end
      S_STRIP: begin
        if (!x_q[0] && !y_q[0]) begin
          x_d = x_q >> 1;
          y_d = y_q >> 1;
          k_d = k_q + KW'(1);
        end else begin
          state_d = S_REDUCE;
        end
      end
      S_REDUCE: begin
        if (!x_q[0]) begin
          x_d = x_q >> 1;
        end else if (!y_q[0]) begin
          y_d = y_q >> 1;
        end else if (x_q == y_q) begin
          o_d     = x_q << k_q;
          state_d = S_DONE;
        end else if (x_q > y_q) begin
          x_d = x_q - y_q;
        end else begin
          y_d = y_q - x_q;
        end
      end
      default: state_d = S_IDLE;
    endcase

    ready_d = (state_d == S_IDLE) || (state_d == S_DONE);
  end

  assign ready = ready_q;
  assign fin   = fin_q;
  assign o     = o_q;

endmodule

// File: tb/tb_gcd_stein.sv
// Directed and randomized checks of gcd_stein (WIDTH=16 and WIDTH=8) against a
// Euclid-based reference model.
module tb_gcd_stein;

  logic clk = 1'b0;
  logic nrst;
  always #5 clk = ~clk;

  logic        start16, ready16, fin16;
  logic [15:0] a16, b16, o16;
  logic        start8, ready8, fin8;
  logic [7:0]  a8, b8, o8;

  int checks = 0;
  int errors = 0;

  gcd_stein #(.WIDTH(16)) u16 (
    .clk(clk), .nrst(nrst), .start(start16), .a(a16), .b(b16),
    .ready(ready16), .fin(fin16), .o(o16)
  );

  gcd_stein #(.WIDTH(8)) u8 (
    .clk(clk), .nrst(nrst), .start(start8), .a(a8), .b(b8),
    .ready(ready8), .fin(fin8), .o(o8)
  );

  function automatic logic [31:0] ref_gcd(input logic [31:0] p, input logic [31:0] q);
    logic [31:0] t;
    while (q != 0) begin
      t = p % q;
      p = q;
      q = t;
    end
    return p;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Counts edges after the accept edge until fin is seen (bounded)
  task automatic wait_fin16(inout int lat);
    while (fin16 !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic op16(input logic [15:0] av, input logic [15:0] bv, output int lat);
    @(negedge clk);
    start16 = 1'b1; a16 = av; b16 = bv;
    @(posedge clk); #1;
    start16 = 1'b0;
    lat = 0;
    wait_fin16(lat);
  endtask

  task automatic op8(input logic [7:0] av, input logic [7:0] bv, output int lat);
    @(negedge clk);
    start8 = 1'b1; a8 = av; b8 = bv;
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = 0;
    while (fin8 !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    int lat;
    logic [7:0] ra, rb;
    logic [7:0] ca [12];

    nrst = 1'b0;
    start16 = 1'b0; a16 = '0; b16 = '0;
    start8  = 1'b0; a8  = '0; b8  = '0;
    #12;
    check("rst_ready", 32'(ready16), 32'd1);
    check("rst_fin",   32'(fin16),   32'd0);
    check("rst_o",     32'(o16),     32'd0);
    @(negedge clk);
    nrst = 1'b1;

    // Reference example: fin exactly 7 edges after accept, then held
    op16(16'd12, 16'd18, lat);
    check("g12_18_lat",   32'(lat),     32'd7);
    check("g12_18_o",     32'(o16),     32'd6);
    check("g12_18_ready", 32'(ready16), 32'd1);
    repeat (3) begin @(posedge clk); #1; end
    check("g12_18_hold_fin", 32'(fin16), 32'd1);
    check("g12_18_hold_o",   32'(o16),   32'd6);

    // Zero operands finish after one edge
    op16(16'd0, 16'd35, lat);
    check("z0_35_lat", 32'(lat), 32'd1);
    check("z0_35_o",   32'(o16), 32'd35);
    op16(16'd0, 16'd0, lat);
    check("z0_0_lat", 32'(lat), 32'd1);
    check("z0_0_o",   32'(o16), 32'd0);
    op16(16'd35, 16'd0, lat);
    check("z35_0_lat", 32'(lat), 32'd1);
    check("z35_0_o",   32'(o16), 32'd35);

    // 14 common twos: 14 strips + exit + one halving + equal -> fin at edge 18
    op16(16'd32768, 16'd16384, lat);
    check("p2_o",   32'(o16), 32'd16384);
    check("p2_lat", 32'(lat), 32'd18);
    op16(16'd65535, 16'd65535, lat);
    check("max_o",     32'(o16),     32'd65535);
    check("max_lat_b", 32'(lat <= 66), 32'd1);
    op16(16'd65521, 16'd65535, lat);
    check("cop_o",     32'(o16),     32'd1);
    check("cop_lat_b", 32'(lat <= 66), 32'd1);

    // start while busy is ignored
    @(negedge clk);
    start16 = 1'b1; a16 = 16'd12; b16 = 16'd18;
    @(posedge clk); #1;
    start16 = 1'b0;
    lat = 0;
    repeat (3) begin @(posedge clk); #1; lat++; end
    check("busy_ready", 32'(ready16), 32'd0);
    @(negedge clk);
    start16 = 1'b1; a16 = 16'd7; b16 = 16'd21;
    @(posedge clk); #1;
    start16 = 1'b0;
    lat++;
    wait_fin16(lat);
    check("busy_lat", 32'(lat), 32'd7);
    check("busy_o",   32'(o16), 32'd6);
    op16(16'd7, 16'd21, lat);
    check("g7_21_o", 32'(o16), 32'd7);

    // Asynchronous reset mid-REDUCE
    @(negedge clk);
    start16 = 1'b1; a16 = 16'd12; b16 = 16'd18;
    @(posedge clk); #1;
    start16 = 1'b0;
    repeat (4) @(posedge clk);
    #1 nrst = 1'b0;
    #1;
    check("arst_fin",   32'(fin16),   32'd0);
    check("arst_o",     32'(o16),     32'd0);
    check("arst_ready", 32'(ready16), 32'd1);
    @(negedge clk);
    nrst = 1'b1;
    op16(16'd9, 16'd6, lat);
    check("g9_6_o", 32'(o16), 32'd3);

    // WIDTH=8: corners then random pairs against the reference model
    ca = '{8'd255, 8'd0, 8'd0, 8'd255, 8'd1, 8'd255, 8'd255, 8'd255, 8'd1, 8'd1, 8'd128, 8'd64};
    for (int i = 0; i < 6; i++) begin
      op8(ca[2*i], ca[2*i+1], lat);
      check("w8_corner_o",     32'(o8), ref_gcd(32'(ca[2*i]), 32'(ca[2*i+1])));
      check("w8_corner_lat_b", 32'(lat <= 34), 32'd1);
    end
    for (int i = 0; i < 40; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      op8(ra, rb, lat);
      check("w8_rand_o",     32'(o8), ref_gcd(32'(ra), 32'(rb)));
      check("w8_rand_lat_b", 32'(lat <= 34), 32'd1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gcd_stein.md
# gcd_stein

Parametrised, multi-cycle greatest-common-divisor engine using the binary (Stein) algorithm: shifts and subtracts only, no divider, no comparator chain beyond one magnitude compare. It supersedes the fixed 16-bit subtractive GCD unit. It adds configurable width, a start/ready handshake, a registered result-valid flag and correct zero-operand handling. The block sits as a standalone arithmetic slave: a controller loads two operands, waits for `fin`, then reads `o`.

## Interface
- `WIDTH`, default 16: operand and result width in bits (≥ 2).
- `KW`, default `$clog2(WIDTH+1)`: width of the common-power-of-two counter (derived, not overridden).

- `clk`  in  1  system clock, all state updates on rising edge.
- `nrst`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; accepted only in a cycle where `ready`=1.
- `a`  in  WIDTH  operand A, sampled when start is accepted.
- `b`  in  WIDTH  operand B, sampled when start is accepted.
- `ready`  out  1  high in IDLE and DONE; block can accept `start`.
- `fin`  out  1  registered; high in DONE, `o` valid.
- `o`  out  WIDTH  result gcd(a,b); held stable while `fin`=1.

## Operation
- Internal registers: `x`, `y` (WIDTH), `k` (KW), state (IDLE, STRIP, REDUCE, DONE), `o` (WIDTH).
- Reset (`nrst`=0, any time, asynchronous): state=IDLE, `x`=`y`=`o`=0, `k`=0. Outputs: `ready`=1, `fin`=0, `o`=0.
- IDLE / DONE, `start`=1: latch `x`=`a`, `y`=`b`, `k`=0; `fin` drops next cycle.
  - If `a`==0 or `b`==0: next state DONE with `o`=`a`|`b` (gcd(0,n)=n, gcd(0,0)=0).
  - Otherwise: next state STRIP.
- IDLE / DONE, `start`=0: hold; DONE keeps `fin`=1 and `o` unchanged indefinitely.
- STRIP, per cycle: if `x[0]`==0 and `y[0]`==0, then `x`>>=1, `y`>>=1, `k`+=1. Otherwise go to REDUCE, with registers unchanged.
- REDUCE, per cycle, first matching rule:
  1. `x` even: `x`>>=1.
  2. `y` even: `y`>>=1.
  3. `x`==`y`: `o`=`x`<<`k`, go to DONE.
  4. `x`>`y`: `x`=`x`-`y`.
  5. Else: `y`=`y`-`x`.
- Arithmetic is unsigned and WIDTH-wide. The subtraction never underflows because rule order guarantees minuend > subtrahend. `x`<<`k` never overflows because the gcd ≤ min(a,b).
- `start` while busy (STRIP/REDUCE, `ready`=0) is ignored; the operation in flight is unaffected.
- `k` never exceeds WIDTH-1 for nonzero operands.

## Timing
- Start accepted at edge 0. A zero operand gives `fin`=1 after edge 1 (1-cycle latency).
- Nonzero operands pass through 1 STRIP cycle per common factor 2, plus 1 STRIP exit cycle, plus REDUCE cycles. `fin` rises the cycle after the `x`==`y` edge.
- Example: gcd(12,18) runs STRIP (6,9,k=1), STRIP exit, then REDUCE (3,9), (3,6), (3,3), and finally `o`=6. `fin`=1 after edge 7.
- Worst-case latency is ≤ 4·WIDTH+2 cycles from accept to `fin`.
- Back-to-back: a new `start` in DONE is accepted the same cycle. `fin`/`ready` of the old result stay high up to that edge.
- Reset asserted mid-operation aborts immediately. `fin`=0, `o`=0, and the first post-reset `start` is accepted normally.

## Test plan
- `a`=12, `b`=18, start 1 cycle -> `fin`=1 exactly 7 cycles after accept, `o`=6, `ready`=1, both held until next start.
- `a`=0, `b`=35 -> `o`=35 one cycle after accept. `a`=0, `b`=0 -> `o`=0, same timing. `a`=35, `b`=0 -> `o`=35.
- `a`=32768, `b`=16384 -> `k` reaches 14, `o`=16384. `a`=65535, `b`=65535 -> `o`=65535. `a`=65521, `b`=65535 -> `o`=1, latency ≤ 66.
- Mid-operation, pulse `start` with `a`=7, `b`=21 while busy on (12,18) -> ignored, `o`=6. Then start (7,21) from DONE -> `o`=7.
- Assert `nrst`=0 asynchronously mid-REDUCE -> `fin`=0, `o`=0, `ready`=1 before the next edge. Then (9,6) -> `o`=3.
- WIDTH=8 instance, random operand pairs checked against a reference gcd model, including 255/0/1 corners -> all `o` match, latency ≤ 34.
